// File: rtl/subkey_if.sv
// Subkey generator bus: the start/key request and the per-round subkey stream.
interface subkey_if;
  logic        start;
  logic        decrypt;
  logic [55:0] droppedKey;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  modport master (
    output start, decrypt, droppedKey,
    input  subkey, subkey_valid, round, busy, done
  );

  modport slave (
    input  start, decrypt, droppedKey,
    output subkey, subkey_valid, round, busy, done
  );
endinterface

// File: rtl/subkey_gen.sv
// DES key schedule: turns a PC-1 reduced key into sixteen PC-2 round subkeys,
// one per cycle, in encrypt order (K1..K16) or, when SUBKEY_DECRYPT_EN is
// defined, optionally in decrypt order (K16..K1) using right rotations.
// Without SUBKEY_DECRYPT_EN the decrypt input is accepted but ignored.
module subkey_gen (
  input  logic     clk,
  input  logic     rst,
  subkey_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  // PC-2 selection: entry n names the DES bit of C||D that feeds subkey bit n.
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
  function automatic logic single_shift(input logic [4:0] i);
    return (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

`ifdef SUBKEY_DECRYPT_EN
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction
`endif

  // Bit 55 of cd is DES bit 1, so DES bit b lives at index 56-b.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] out;
    out = '0;
    for (int n = 0; n < 48; n++) begin
      out[6'(47 - n)] = cd[6'(56 - PC2_TAB[n])];
    end
    return out;
  endfunction

  state_t      state, state_n;
  logic [27:0] c_q, c_n, d_q, d_n;
  logic [27:0] c_step, d_step;
  logic [3:0]  idx_q, idx_n;     // index of the last emitted step, 0..15
  logic [3:0]  round_q, round_n;
  logic [47:0] key_q, key_n;
  logic        vld_q, vld_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
`ifdef SUBKEY_DECRYPT_EN
  logic        mode_q, mode_n;
`else
  logic        unused_decrypt;
  assign unused_decrypt = bus.decrypt;
`endif

  // Register the FSM, the rotating C/D halves and the subkey outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      round_q <= '0;
      key_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUBKEY_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      c_q     <= c_n;
      d_q     <= d_n;
      idx_q   <= idx_n;
      round_q <= round_n;
      key_q   <= key_n;
      vld_q   <= vld_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef SUBKEY_DECRYPT_EN
      mode_q  <= mode_n;
`endif
    end
  end

  // Next-state and next-output logic: one rotation step and one subkey per RUN cycle.
  always_comb begin
    state_n = state;
    c_n     = c_q;
    d_n     = d_q;
    c_step  = c_q;
    d_step  = d_q;
    idx_n   = idx_q;
    round_n = round_q;
    key_n   = key_q;
    vld_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
`ifdef SUBKEY_DECRYPT_EN
    mode_n  = mode_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          idx_n   = 4'd0;
          vld_n   = 1'b1;
          busy_n  = 1'b1;
`ifdef SUBKEY_DECRYPT_EN
          mode_n  = bus.decrypt;
          if (bus.decrypt) begin
            // Total rotation over 16 rounds is 28, so K16 uses C0/D0 as-is.
            c_step  = bus.droppedKey[55:28];
            d_step  = bus.droppedKey[27:0];
            round_n = 4'd15;
          end else begin
            c_step  = rotl28(bus.droppedKey[55:28], 1'b1);
            d_step  = rotl28(bus.droppedKey[27:0], 1'b1);
            round_n = 4'd0;
          end
`else
          c_step  = rotl28(bus.droppedKey[55:28], 1'b1);
          d_step  = rotl28(bus.droppedKey[27:0], 1'b1);
          round_n = 4'd0;
`endif
          c_n   = c_step;
          d_n   = d_step;
          key_n = pc2({c_step, d_step});
        end
      end
      RUN: begin
        if (idx_q == 4'd15) begin
          state_n = IDLE;
        end else begin
          idx_n  = idx_q + 4'd1;
          vld_n  = 1'b1;
          busy_n = 1'b1;
          done_n = (idx_q == 4'd14);
`ifdef SUBKEY_DECRYPT_EN
          if (mode_q) begin
            // Step j = idx+2 undoes the rotation of round 18-j = 16-idx.
            c_step  = rotr28(c_q, single_shift(5'd16 - {1'b0, idx_q}));
            d_step  = rotr28(d_q, single_shift(5'd16 - {1'b0, idx_q}));
            round_n = round_q - 4'd1;
          end else begin
            c_step  = rotl28(c_q, single_shift({1'b0, idx_q} + 5'd2));
            d_step  = rotl28(d_q, single_shift({1'b0, idx_q} + 5'd2));
            round_n = round_q + 4'd1;
          end
`else
          c_step  = rotl28(c_q, single_shift({1'b0, idx_q} + 5'd2));
          d_step  = rotl28(d_q, single_shift({1'b0, idx_q} + 5'd2));
          round_n = round_q + 4'd1;
`endif
          c_n   = c_step;
          d_n   = d_step;
          key_n = pc2({c_step, d_step});
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.subkey       = key_q;
  assign bus.subkey_valid = vld_q;
  assign bus.round        = round_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_subkey_gen.sv
// Testbench for subkey_gen: reference key schedule built from cumulative
// rotations of C0/D0 and the PC-2 table in DES bit numbering.
module tb_subkey_gen;

  logic clk;
  logic rst;
  subkey_if bus ();

  subkey_gen dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  localparam logic [55:0] KNOWN_KEY = 56'hF0CCAAF556678F;
  localparam int PC2_REF [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_key   [16];
  logic [3:0]  exp_round [16];
  logic [47:0] obs_key   [16];
  logic [3:0]  obs_round [16];

  function automatic logic [27:0] rot_left(input logic [27:0] x, input int n);
    logic [55:0] t;
    int m;
    m = n % 28;
    t = {x, x};
    return t[55 - m -: 28];
  endfunction

  // Ks[i] is PC-2 of C/D rotated by the sum of the first i shifts.
  task automatic build_model(input logic [55:0] key, input bit dec);
    logic [47:0] ks [17];
    logic [27:0] c, d;
    logic [55:0] cd;
    bit   eff;
    int   cum;
    cum = 0;
    for (int i = 1; i <= 16; i++) begin
      cum = cum + SHIFTS[i - 1];
      c = rot_left(key[55:28], cum);
      d = rot_left(key[27:0], cum);
      cd = {c, d};
      for (int n = 1; n <= 48; n++) ks[i][48 - n] = cd[56 - PC2_REF[n - 1]];
    end
`ifdef SUBKEY_DECRYPT_EN
    eff = dec;
`else
    eff = 1'b0;
`endif
    for (int j = 1; j <= 16; j++) begin
      if (eff) begin
        exp_key[j - 1]   = ks[17 - j];
        exp_round[j - 1] = 4'(16 - j);
      end else begin
        exp_key[j - 1]   = ks[j];
        exp_round[j - 1] = 4'(j - 1);
      end
    end
  endtask

  // Launches a schedule at the current falling edge and checks all 16 steps;
  // returns at the falling edge that shows the done pulse.
  task automatic run_schedule(input logic [55:0] key, input bit dec, input bit scramble);
    build_model(key, dec);
    bus.start      = 1'b1;
    bus.droppedKey = key;
    bus.decrypt    = dec;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      obs_key[i]   = bus.subkey;
      obs_round[i] = bus.round;
      vectors += 5;
      if (bus.subkey_valid !== 1'b1) begin
        miscompares++; $display("FAIL valid step %0d: got %b want 1", i, bus.subkey_valid);
      end
      if (bus.subkey !== exp_key[i]) begin
        miscompares++; $display("FAIL subkey step %0d: got %h want %h", i, bus.subkey, exp_key[i]);
      end
      if (bus.round !== exp_round[i]) begin
        miscompares++; $display("FAIL round step %0d: got %0d want %0d", i, bus.round, exp_round[i]);
      end
      if (bus.busy !== 1'b1) begin
        miscompares++; $display("FAIL busy step %0d: got %b want 1", i, bus.busy);
      end
      if (bus.done !== (i == 15)) begin
        miscompares++; $display("FAIL done step %0d: got %b want %b", i, bus.done, (i == 15));
      end
      if (scramble && i < 15) begin
        bus.droppedKey = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
        bus.decrypt    = 1'($urandom);
        bus.start      = 1'($urandom);
      end
    end
    bus.start = 1'b0;
  endtask

  // Cycle after done: idle, subkey holding its last value.
  task automatic idle_check(input string tag);
    @(negedge clk);
    vectors += 4;
    if (bus.subkey_valid !== 1'b0) begin
      miscompares++; $display("FAIL %s idle valid: got %b want 0", tag, bus.subkey_valid);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL %s idle busy: got %b want 0", tag, bus.busy);
    end
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL %s idle done: got %b want 0", tag, bus.done);
    end
    if (bus.subkey !== exp_key[15]) begin
      miscompares++; $display("FAIL %s idle hold: got %h want %h", tag, bus.subkey, exp_key[15]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.decrypt = 1'b0; bus.droppedKey = '0;
    repeat (2) @(negedge clk);
    vectors += 5;
    if (bus.subkey !== 48'h0) begin miscompares++; $display("FAIL reset subkey: got %h want 0", bus.subkey); end
    if (bus.subkey_valid !== 1'b0) begin miscompares++; $display("FAIL reset valid: got %b want 0", bus.subkey_valid); end
    if (bus.round !== 4'd0) begin miscompares++; $display("FAIL reset round: got %0d want 0", bus.round); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", bus.done); end
    rst = 1'b0;
    run_schedule(KNOWN_KEY, 1'b0, 1'b0);
    idle_check("post_reset");
  endtask

  task automatic test_encrypt_known();
    run_schedule(KNOWN_KEY, 1'b0, 1'b0);
    vectors += 4;
    if (obs_key[0] !== 48'h1B02EFFC7072) begin miscompares++; $display("FAIL enc K1: got %h want 1b02effc7072", obs_key[0]); end
    if (obs_round[0] !== 4'd0) begin miscompares++; $display("FAIL enc first round: got %0d want 0", obs_round[0]); end
    if (obs_key[15] !== 48'hCB3D8B0E17F5) begin miscompares++; $display("FAIL enc K16: got %h want cb3d8b0e17f5", obs_key[15]); end
    if (obs_round[15] !== 4'd15) begin miscompares++; $display("FAIL enc last round: got %0d want 15", obs_round[15]); end
    idle_check("enc_known");
  endtask

  task automatic test_decrypt_known();
    logic [47:0] want_first, want_last;
    logic [3:0]  want_r0, want_r15;
`ifdef SUBKEY_DECRYPT_EN
    want_first = 48'hCB3D8B0E17F5; want_last = 48'h1B02EFFC7072; want_r0 = 4'd15; want_r15 = 4'd0;
`else
    want_first = 48'h1B02EFFC7072; want_last = 48'hCB3D8B0E17F5; want_r0 = 4'd0; want_r15 = 4'd15;
`endif
    run_schedule(KNOWN_KEY, 1'b1, 1'b0);
    vectors += 4;
    if (obs_key[0] !== want_first) begin miscompares++; $display("FAIL dec first: got %h want %h", obs_key[0], want_first); end
    if (obs_round[0] !== want_r0) begin miscompares++; $display("FAIL dec first round: got %0d want %0d", obs_round[0], want_r0); end
    if (obs_key[15] !== want_last) begin miscompares++; $display("FAIL dec last: got %h want %h", obs_key[15], want_last); end
    if (obs_round[15] !== want_r15) begin miscompares++; $display("FAIL dec last round: got %0d want %0d", obs_round[15], want_r15); end
    idle_check("dec_known");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_schedule({$urandom, $urandom} & 56'hFFFFFFFFFFFFFF, 1'($urandom), 1'b0);
      idle_check("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_start_held();
    int nvalid;
    bit settled;
    nvalid = 0;
    build_model(KNOWN_KEY, 1'b0);
    bus.start = 1'b1; bus.droppedKey = KNOWN_KEY; bus.decrypt = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 17 && bus.subkey_valid === 1'b1) nvalid++;
      if (c <= 16) begin
        vectors += 2;
        if (bus.subkey !== exp_key[c - 1]) begin miscompares++; $display("FAIL held subkey c%0d: got %h want %h", c, bus.subkey, exp_key[c - 1]); end
        if (bus.done !== (c == 16)) begin miscompares++; $display("FAIL held done c%0d: got %b want %b", c, bus.done, (c == 16)); end
      end
      if (c == 17) begin
        vectors++;
        if (bus.subkey_valid !== 1'b0) begin miscompares++; $display("FAIL held gap valid: got %b want 0", bus.subkey_valid); end
      end
      if (c == 18) begin
        vectors += 3;
        if (bus.subkey_valid !== 1'b1) begin miscompares++; $display("FAIL held restart valid: got %b want 1", bus.subkey_valid); end
        if (bus.subkey !== exp_key[0]) begin miscompares++; $display("FAIL held restart key: got %h want %h", bus.subkey, exp_key[0]); end
        if (bus.round !== 4'd0) begin miscompares++; $display("FAIL held restart round: got %0d want 0", bus.round); end
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (nvalid != 16) begin miscompares++; $display("FAIL held count: got %0d want 16", nvalid); end
    settled = 1'b0;
    for (int w = 0; w < 40 && !settled; w++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.subkey_valid === 1'b0) settled = 1'b1;
    end
    vectors++;
    if (!settled) begin miscompares++; $display("FAIL held settle: got busy %b want 0 within 40 cycles", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    found = 1'b0;
    bus.start = 1'b1; bus.droppedKey = KNOWN_KEY; bus.decrypt = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.subkey_valid === 1'b1 && bus.round === 4'd7) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL rst_mid reach round7: got none want round 7 within 20 cycles"); end
    rst = 1'b1;
    #1;
    vectors += 5;
    if (bus.subkey !== 48'h0) begin miscompares++; $display("FAIL rst_mid subkey: got %h want 0", bus.subkey); end
    if (bus.subkey_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid valid: got %b want 0", bus.subkey_valid); end
    if (bus.round !== 4'd0) begin miscompares++; $display("FAIL rst_mid round: got %0d want 0", bus.round); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_mid done: got %b want 0", bus.done); end
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      vectors += 2;
      if (bus.subkey_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid after valid: got %b want 0", bus.subkey_valid); end
      if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_mid after done: got %b want 0", bus.done); end
    end
    run_schedule(KNOWN_KEY, 1'b0, 1'b0);
    vectors++;
    if (obs_key[0] !== 48'h1B02EFFC7072) begin miscompares++; $display("FAIL rst_mid K1: got %h want 1b02effc7072", obs_key[0]); end
    idle_check("rst_mid");
  endtask

  task automatic test_key_change();
    run_schedule(KNOWN_KEY, 1'b0, 1'b1);
    idle_check("key_change");
    run_schedule({$urandom, $urandom} & 56'hFFFFFFFFFFFFFF, 1'b1, 1'b1);
    idle_check("key_change_dec");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      run_schedule({$urandom, $urandom} & 56'hFFFFFFFFFFFFFF, 1'($urandom), 1'b0);
      idle_check("b2b");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.decrypt = 1'b0;
    bus.droppedKey = '0;
    for (int i = 0; i < 16; i++) begin exp_key[i] = '0; exp_round[i] = '0; end
    test_reset();
    test_encrypt_known();
    test_decrypt_known();
    test_random();
    test_start_held();
    test_reset_mid_run();
    test_key_change();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/subkey_gen.md
SUBKEY_GEN -- requirements
Module: subkey_gen

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous and active-high.
REQ-003 SHALL have port: start  input  1  request to begin a 16-round schedule; sampled in IDLE only.
REQ-004 SHALL have port: decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with start.
REQ-005 SHALL have port: droppedKey  input  56  PC-1 output; bit 55 = DES bit 1 (first bit of C0), bit 0 = DES bit 56.
REQ-006 SHALL have port: subkey  output  48  current round subkey after PC-2; bit 47 = DES bit 1.
REQ-007 SHALL have port: subkey_valid  output  1  subkey holds a valid round key this cycle.
REQ-008 SHALL have port: round  output  4  index of emitted subkey, 0..15 meaning K1..K16.
REQ-009 SHALL have port: busy  output  1  schedule in progress; start ignored.
REQ-010 SHALL have port: done  output  1  one-cycle pulse coincident with the 16th valid subkey.

Function
REQ-011 SHALL implement states IDLE and RUN; IDLE->RUN on start=1; RUN->IDLE after 16th subkey.
REQ-012 SHALL, on start in IDLE, latch C = droppedKey[55:28], D = droppedKey[27:0] and latch decrypt into a mode register.
REQ-013 SHALL use shift table s(i) = 1 for i in {1,2,9,16}, else 2, for i = 1..16.
REQ-014 SHALL, in encrypt mode, emit round j (j = 1..16) from C,D each rotated left by s(j) from the round j-1 value.
REQ-015 SHALL, in decrypt mode, emit first subkey from unrotated C0,D0 (K16) and each later step j (2..16) from the previous C,D rotated right by s(18-j).
REQ-016 SHALL compute subkey via PC-2 table 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32, entry n mapping CD bit (56-n) to subkey bit (48-position).
REQ-017 SHALL register subkey; first valid subkey appears the cycle after start is accepted; one subkey per cycle thereafter, 16 consecutive cycles.
REQ-018 SHALL assert busy from the cycle after start acceptance through the 16th valid cycle, deasserting with return to IDLE.
REQ-019 SHALL report round = 0..15 in encrypt mode and 15..0 in decrypt mode, matching the emitted Kn.
REQ-020 SHALL ignore start and changes to droppedKey/decrypt while busy=1.
REQ-021 SHALL accept start asserted in the cycle immediately after done, giving back-to-back schedules with no gap beyond one cycle.
REQ-022 SHALL hold subkey at its last value and drive subkey_valid=0 in IDLE.

Reset
REQ-023 SHALL, on rst=1, immediately clear subkey, C, D, round, mode to 0 and subkey_valid, busy, done to 0, state IDLE.
REQ-024 SHALL abort a schedule in progress on rst with no further valid subkeys or done pulse after release.
REQ-025 SHALL accept start in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with SUBKEY_DECRYPT_EN defined, implement decrypt mode as in REQ-015/REQ-019.
REQ-027 SHALL, without SUBKEY_DECRYPT_EN, keep the decrypt port but ignore it, always running encrypt order, with no right-rotate logic present.

Verification
REQ-028 SHALL cover: droppedKey=F0CCAAF556678F, decrypt=0, start pulse -> 16 valid cycles, first subkey 1B02EFFC7072, round 0; 16th subkey CB3D8B0E17F5, round 15, done=1.
REQ-029 SHALL cover: same key, decrypt=1 (macro defined) -> first subkey CB3D8B0E17F5 round 15, last 1B02EFFC7072 round 0 with done.
REQ-030 SHALL cover: start held high for 20 cycles -> exactly one schedule in first 17 cycles, new schedule begins on the cycle after done.
REQ-031 SHALL cover: rst pulsed during round 7 -> outputs 0 immediately, no done, next start yields correct K1=1B02EFFC7072.
REQ-032 SHALL cover: droppedKey changed mid-run -> emitted sequence unchanged from latched key.
REQ-033 SHALL cover: macro undefined, decrypt=1 -> encrypt-order sequence identical to REQ-028.
